// File: rtl/heap_sched.sv
// Frame sequencer in front of a heap sorter: init, paced inserts, flush and
// drain window, with the heap's sorted output forwarded one cycle later.
module heap_sched #(
  parameter int DATA_WIDTH   = 16,
  parameter int KEY_WIDTH    = 4,
  parameter int NLEVELS      = 7,
  parameter int INIT_CYCLES  = 2**(NLEVELS+1),
  parameter int FLUSH_CYCLES = 2*(2**(NLEVELS+1)-1)+4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  abort,
  output logic                  heap_init,
  output logic                  heap_en,
  output logic                  heap_flush,
  output logic [DATA_WIDTH-1:0] heap_din,
  input  logic [DATA_WIDTH-1:0] heap_dout,
  input  logic                  heap_valid,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [15:0]           in_cnt,
  output logic [15:0]           out_cnt
);

  if (KEY_WIDTH > DATA_WIDTH - 2) begin : g_key_overlaps_flags
    $error("heap_sched: KEY_WIDTH overlaps the flag field");
  end

  localparam int TMAX = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INIT_LAST  = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INIT, LOAD, HOLD, FLUSH, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  last_q, last_d;
  logic                  accept, start;
  logic [15:0]           in_cnt_q, in_cnt_d, out_base, out_cnt_q, out_cnt_d;
  logic                  s_ready_q, heap_init_q, heap_en_q, heap_flush_q, busy_q, m_valid_q;
  logic [DATA_WIDTH-1:0] heap_din_q, m_data_q;

  assign start  = (state_q == IDLE) && s_valid;
  assign accept = (state_q == LOAD) && s_valid && !abort;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE:  if (s_valid) begin state_d = INIT; tmr_d = '0; end
      INIT:  if (tmr_q == INIT_LAST) state_d = LOAD;
             else tmr_d = tmr_q + 1'b1;
      LOAD:  if (s_valid) begin state_d = HOLD; last_d = s_last; end
      HOLD:  state_d = last_q ? FLUSH : LOAD;
      FLUSH: begin state_d = DRAIN; tmr_d = '0; end
      DRAIN: if (tmr_q == FLUSH_LAST) state_d = IDLE;
             else tmr_d = tmr_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // abort outranks any accept, s_last or timer expiry this cycle
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    in_cnt_d = in_cnt_q;
    if (start) in_cnt_d = '0;
    else if (accept && in_cnt_q != 16'hFFFF) in_cnt_d = in_cnt_q + 16'd1;
    out_base  = start ? 16'd0 : out_cnt_q;
    out_cnt_d = (heap_valid && out_base != 16'hFFFF) ? out_base + 16'd1 : out_base;
  end

  // Controls are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      last_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      heap_init_q  <= 1'b0;
      heap_en_q    <= 1'b0;
      heap_flush_q <= 1'b0;
      busy_q       <= 1'b0;
      heap_din_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      last_q       <= last_d;
      s_ready_q    <= (state_d == LOAD);
      heap_init_q  <= (state_d == INIT);
      heap_en_q    <= (state_d == HOLD);
      heap_flush_q <= (state_d == FLUSH);
      busy_q       <= (state_d != IDLE);
      if (accept) heap_din_q <= s_data;
      m_valid_q    <= heap_valid;
      if (heap_valid) m_data_q <= heap_dout;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign heap_init  = heap_init_q;
  assign heap_en    = heap_en_q;
  assign heap_flush = heap_flush_q;
  assign heap_din   = heap_din_q;
  assign busy       = busy_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign in_cnt     = in_cnt_q;
  assign out_cnt    = out_cnt_q;

endmodule

// File: doc/heap_sched.md
HEAP_SCHED -- requirements
Module: heap_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the item width (bits [DW-1:DW-2] are the flag field, 2'b00 marks a normal item).
REQ-002 SHALL have parameter KEY_WIDTH, default 4, meaning the sort key width (bits [KW-1:0]).
REQ-003 SHALL have parameter NLEVELS, default 7, meaning the heap depth; HEAP_SIZE = 2^(NLEVELS+1)-1.
REQ-004 SHALL have parameter INIT_CYCLES, default HEAP_SIZE+1, meaning the number of cycles heap_init is held high.
REQ-005 SHALL have parameter FLUSH_CYCLES, default 2*HEAP_SIZE+4, meaning the number of cycles the drain window stays open after the heap_flush pulse.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have ports s_valid (input, 1), s_data (input, DATA_WIDTH) and s_last (input, 1): the input item stream; s_last marks the final item of a frame.
REQ-009 SHALL have port s_ready, output, 1 bit: the item is accepted in a cycle where s_valid and s_ready are both high.
REQ-010 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-011 SHALL have ports heap_init, heap_en, heap_flush (outputs, 1 bit each) and heap_din (output, DATA_WIDTH): control and data to the heap sorter.
REQ-012 SHALL have ports heap_dout (input, DATA_WIDTH) and heap_valid (input, 1 bit): the sorted result from the heap.
REQ-013 SHALL have ports m_valid (output, 1) and m_data (output, DATA_WIDTH): the forwarded result stream; it has no backpressure.
REQ-014 SHALL have port busy (output, 1 bit): high whenever state is not IDLE.
REQ-015 SHALL have ports in_cnt (output, 16 bits), items accepted in the current frame, and out_cnt (output, 16 bits), results forwarded in the current frame.

Function
REQ-016 SHALL implement states IDLE, INIT, LOAD, HOLD, FLUSH, DRAIN.
REQ-017 SHALL behave as follows in IDLE: s_ready=0; on s_valid=1, clear in_cnt and out_cnt and go to INIT next cycle.
REQ-018 SHALL behave as follows in INIT: heap_init=1 for exactly INIT_CYCLES consecutive cycles, s_ready=0, then go to LOAD.
REQ-019 SHALL behave as follows in LOAD: s_ready=1; on accept, register s_data into heap_din, pulse heap_en for one cycle, increment in_cnt and go to HOLD.
REQ-020 SHALL, in HOLD, keep s_ready=0 and heap_din unchanged for one cycle, so the heap samples din the cycle after en; the maximum insert rate is one item every 2 cycles.
REQ-021 SHALL, on leaving HOLD, go to FLUSH if the accepted item had s_last=1; otherwise return to LOAD.
REQ-022 SHALL behave as follows in FLUSH: heap_flush=1 for exactly one cycle, then go to DRAIN.
REQ-023 SHALL behave as follows in DRAIN: count FLUSH_CYCLES cycles, then go to IDLE; heap_en and heap_init stay 0.
REQ-024 SHALL, in every state, register m_valid <= heap_valid and m_data <= heap_dout (1-cycle latency) and increment out_cnt on each heap_valid.
REQ-025 SHALL hold m_data at its previous value when heap_valid=0.
REQ-026 SHALL saturate in_cnt and out_cnt at 16'hFFFF with no wrap.
REQ-027 SHALL NOT limit in_cnt to HEAP_SIZE: beyond HEAP_SIZE items the heap emits the displaced items, which are forwarded normally.
REQ-028 SHALL ignore s_valid outside LOAD; items are neither consumed nor dropped, since s_ready=0.
REQ-029 SHALL, on abort=1 in any state except IDLE, go to IDLE next cycle with all heap controls 0, discarding any pending flush; counters keep their values until the next frame starts.
REQ-030 SHALL give abort priority over an accept, s_last and timer expiry in the same cycle.
REQ-031 SHALL, on an item with s_last=1 whose flag is non-zero, still insert it and flush.
REQ-032 SHALL, on s_valid=1 in the same cycle IDLE is re-entered from DRAIN, start the new frame's INIT on the following cycle.
REQ-033 SHALL ensure heap_en, heap_init and heap_flush are never high in the same cycle.

Reset
REQ-034 SHALL, while rstn=0, force state=IDLE and all outputs to 0 (s_ready, heap_*, m_valid, m_data, busy, in_cnt, out_cnt); release is synchronous to the next clk edge.
REQ-035 SHALL, on reset mid-frame, drop the frame; the next frame always begins with a full INIT.

Verification (NLEVELS=2: HEAP_SIZE=7, INIT_CYCLES=8, FLUSH_CYCLES=18)
REQ-036 SHALL verify basic frame: after reset, s_valid held with keys 5,3,9 (last on 9) -> 8 cycles of heap_init, heap_en pulses 2 cycles apart, one heap_flush, in_cnt=3, busy falls 19 cycles after the flush pulse.
REQ-037 SHALL verify the handshake: s_valid held continuously for 4 items -> s_ready toggles 1,0,1,0; heap_din stays stable across each en cycle and the following cycle.
REQ-038 SHALL verify forwarding: heap_valid pulsed with heap_dout=16'h0007 -> m_valid=1 and m_data=16'h0007 exactly one cycle later, out_cnt+1.
REQ-039 SHALL verify abort: abort=1 during the 3rd init cycle -> heap_init=0 and busy=0 next cycle, no heap_en pulse and no heap_flush pulse occur.
REQ-040 SHALL verify reset: rstn=0 in DRAIN -> all outputs 0 immediately; a new s_valid produces a fresh 8-cycle INIT.
REQ-041 SHALL verify overflow: a 10-item frame -> in_cnt=10 and exactly 10 heap_en pulses, none of them overlapping heap_init or heap_flush.
